// File: rtl/fold_scheduler.sv
// fold_scheduler: sole owner of the folded-profile RAM port. Queues pulse
// bin events and applies them as read-modify-write increments, runs the
// clear and dump sweeps, and keeps event/drop/saturation statistics.
// Ports: clk, rst (async, high); pulse_valid/pulse_bin/pulse_ready event
// input; clear_start/dump_start sweep requests; mem_addr/mem_re/mem_we/
// mem_wdata/mem_rdata RAM port; dump_valid/dump_bin/dump_value/dump_ready/
// dump_done dump stream; busy, event_count, drop_count, sat_flag status.
module fold_scheduler #(
  parameter int BINS       = 1024,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_valid,
  input  logic [ADDR_W-1:0] pulse_bin,
  output logic              pulse_ready,
  input  logic              clear_start,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_bin,
  output logic [DATA_W-1:0] dump_value,
  input  logic              dump_ready,
  output logic              dump_done,
  output logic              busy,
  output logic [31:0]       event_count,
  output logic [15:0]       drop_count,
  output logic              sat_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   BINS_L = (ADDR_W+1)'(BINS);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(BINS - 1);
  localparam logic [PW:0]       FULL_N = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ACC_RD, ACC_WR, CLEAR, DUMP_RD, DUMP_WAIT
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr_q, addr_n, head;
  logic              clr_pend, dump_pend;
  logic              dump_first, dump_done_q;
  logic [DATA_W-1:0] dump_q;
  logic [31:0]       event_q;
  logic [15:0]       drop_q;
  logic              sat_q;
  logic              full, empty, in_range;
  logic              push, pop, drop;
  logic              rmw_sat, go_clear, go_dump;

  assign full     = (count == FULL_N);
  assign empty    = (count == '0);
  assign in_range = ({1'b0, pulse_bin} < BINS_L);
  assign push     = pulse_valid && !full && in_range;
  assign drop     = pulse_valid && (full || !in_range);
  assign pop      = (state == ACC_RD);
  assign head     = fifo_q[rd_ptr];
  assign rmw_sat  = (mem_rdata == '1);
  assign go_clear = (state == IDLE) && clr_pend;
  assign go_dump  = (state == IDLE) && !clr_pend && dump_pend;

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    mem_addr  = addr_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (clr_pend) begin
          state_n = CLEAR;
          addr_n  = '0;
        end else if (dump_pend) begin
          state_n = DUMP_RD;
          addr_n  = '0;
        end else if (!empty) begin
          state_n = ACC_RD;
        end
      end
      ACC_RD: begin
        mem_addr = head;
        mem_re   = 1'b1;
        addr_n   = head;
        state_n  = ACC_WR;
      end
      ACC_WR: begin
        mem_we    = 1'b1;
        mem_wdata = rmw_sat ? '1 : mem_rdata + DATA_W'(1);
        state_n   = IDLE;
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (addr_q == LAST) state_n = IDLE;
        else addr_n = addr_q + ADDR_W'(1);
      end
      DUMP_RD: begin
        mem_re  = 1'b1;
        state_n = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (dump_ready) begin
          if (addr_q == LAST) begin
            state_n = IDLE;
          end else begin
            addr_n  = addr_q + ADDR_W'(1);
            state_n = DUMP_RD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Read data is only valid in the first wait cycle; after that the
  // captured copy holds the word steady while the consumer stalls.
  assign dump_valid  = (state == DUMP_WAIT);
  assign dump_value  = !dump_valid ? '0 :
                       dump_first ? mem_rdata : dump_q;
  assign dump_bin    = dump_valid ? addr_q : '0;
  assign dump_done   = dump_done_q;
  assign pulse_ready = !rst && !full;
  assign busy        = (state != IDLE) || !empty ||
                       clr_pend || dump_pend;
  assign event_count = event_q;
  assign drop_count  = drop_q;
  assign sat_flag    = sat_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= pulse_bin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      clr_pend    <= 1'b0;
      dump_pend   <= 1'b0;
      dump_first  <= 1'b0;
      dump_done_q <= 1'b0;
      dump_q      <= '0;
      event_q     <= '0;
      drop_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
      // A request seen while its own sweep runs is absorbed.
      clr_pend <= go_clear ? 1'b0 :
                  clr_pend || (clear_start && state != CLEAR);
      dump_pend <= go_dump ? 1'b0 :
                   dump_pend || (dump_start &&
                   state != DUMP_RD && state != DUMP_WAIT);
      dump_first <= (state == DUMP_RD);
      if (dump_first) dump_q <= mem_rdata;
      dump_done_q <= (state == DUMP_WAIT) && dump_ready &&
                     (addr_q == LAST);
      if (state == ACC_WR) begin
        if (event_q != '1) event_q <= event_q + 32'd1;
        if (rmw_sat) sat_q <= 1'b1;
      end
      if (drop && drop_q != '1) drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: doc/fold_scheduler.md
Name: fold_scheduler

Overview:
Owns the single port of the folded-profile memory and sequences every access to it. Detected-pulse bin indices from the phase calculator are queued and applied as read-modify-write increments. A clear sweep zeroes the profile, and a dump sweep streams all bins to the peak finder and distribution logic. It sits between time_phase_calculator and the profile RAM, and is the only block that drives RAM address and write enable.

Parameters:
BINS, 1024, number of profile bins (2..1024)
ADDR_W, 10, bin address width
DATA_W, 32, profile word width
FIFO_DEPTH, 8, pulse-event queue depth (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pulse_valid  in  1  bin event from phase calculator
pulse_bin  in  ADDR_W  bin index of event
pulse_ready  out  1  queue not full
clear_start  in  1  one-cycle request: zero all bins
dump_start  in  1  one-cycle request: stream all bins
mem_addr  out  ADDR_W  RAM address
mem_re  out  1  RAM read strobe
mem_we  out  1  RAM write strobe
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_re
dump_valid  out  1  dump word valid
dump_bin  out  ADDR_W  bin of dump word
dump_value  out  DATA_W  bin contents
dump_ready  in  1  consumer accepts dump word
dump_done  out  1  one-cycle pulse after last bin accepted
busy  out  1  state != IDLE or queue non-empty
event_count  out  32  increments applied, saturating
drop_count  out  16  events lost, saturating
sat_flag  out  1  sticky: some bin saturated

Behaviour:
- Reset (async, rst=1): state IDLE, queue empty, pending flags 0; all outputs 0 except pulse_ready=0 while rst=1 and 1 after release. Counters and sat_flag are 0. RAM contents are untouched; software must issue a clear.
- Enqueue: pulse_valid&&pulse_ready pushes pulse_bin.
- Drops: pulse_valid with queue full, or pulse_bin>=BINS. Either case increments drop_count; the event is not queued. The source cannot stall.
- clear_start and dump_start set sticky pending flags. Flags are cleared when their sweep begins. A repeat while pending or active is absorbed.
- FSM states: IDLE, ACC_RD, ACC_WR, CLEAR, DUMP_RD, DUMP_WAIT.
- IDLE priority: clear pending > dump pending > queue non-empty. Pending sweeps start only from IDLE, so an in-flight RMW always completes first.
- ACC_RD: pop head; mem_addr=bin, mem_re=1 -> ACC_WR.
- ACC_WR: mem_we=1, same addr. mem_wdata=mem_rdata+1, saturating at all-ones; a saturating write sets sat_flag. event_count increments -> IDLE. Throughput is one event per 3 cycles (RD, WR, IDLE). No address overlap, so no hazard forwarding is needed.
- CLEAR: mem_we=1, wdata=0, addr 0..BINS-1, one per cycle; BINS cycles, then IDLE. The queue keeps accepting events during the sweep.
- DUMP_RD: mem_re at current addr -> DUMP_WAIT.
- DUMP_WAIT: capture mem_rdata into dump_value, assert dump_valid, dump_bin=addr.
  - dump_value must not change while dump_valid && !dump_ready.
  - On acceptance at the last bin: pulse dump_done, return to IDLE.
  - Otherwise on acceptance: addr+1 -> DUMP_RD.
- During sweeps no accumulation occurs; queued events wait.
- mem_re and mem_we are never both 1. Both are 0 in IDLE.
- Simultaneous clear_start and dump_start: clear runs first, then dump (dumps zeros).
- Reset mid-sweep or mid-RMW aborts immediately. A partial RMW may leave the bin unincremented.

Test Plan:
- Reset, clear_start, BINS=16 -> 16 consecutive mem_we with wdata=0, addr 0..15; then IDLE, busy=0.
- After clear, events at bins 3,3,7 -> RAM[3]=2, RAM[7]=1, event_count=3, drop_count=0.
- 12 back-to-back events, FIFO_DEPTH=8, queue idle at start:
  - pulse_ready drops once the queue is full.
  - drop_count equals the events rejected while full.
  - event_count+drop_count=12.
- Dump with dump_ready held low 5 cycles on bin 2 -> dump_value stable for those cycles; bins 0..15 streamed in order; dump_done pulses once after bin 15.
- Preload RAM[5]=0xFFFFFFFF, event on bin 5 -> RAM[5] stays 0xFFFFFFFF, sat_flag=1.
- Dump_start during an active clear, plus pulse_bin=20 with BINS=16:
  - dump starts only after the clear completes.
  - the out-of-range event increments drop_count.
  - asserting rst mid-dump returns all outputs to reset values within the same cycle.
